pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and control-flow unit for a five-stage pipeline. Each cycle it
// chooses whether the front-end stage registers advance, which stages get a
// bubble, and whether the PC is redirected to the interrupt or exception
// vector. It also freezes the pipeline while a multi-cycle multiply/divide
// runs and counts stall cycles.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low
//   ID_Rs, ID_Rt   source registers of the ID instruction
//   ID_UsesRt      ID instruction reads Rt
//   EX_MemRead     EX instruction is a load ...
//   EX_Rt          ... with this destination register
//   EX_Branch_EN   taken branch resolved in EX
//   ID_Jump        jump (J/JAL/JR/JALR) in ID
//   ID_EXP_Req     undefined instruction decoded in ID
//   IRQ_in         external interrupt, level, asynchronous to clk
//   Kernel         IF PC bit 31; masks interrupts when 1
//   EX_MD_Start    multiply/divide starts in EX
//   MD_Done        multiply/divide result ready
//   PC_Write, IFID_Write, IDEX_Write   stage enables (1 = advance)
//   IFID_Flush, IDEX_Flush            bubble insert at the next edge
//   ID_IRQ, ID_EXP                    PC-source selects for the vectors
//   Stall_Cnt      saturating count of cycles with PC_Write = 0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_Branch_EN,
    input  logic        ID_Jump,
    input  logic        ID_EXP_Req,
    input  logic        IRQ_in,
    input  logic        Kernel,
    input  logic        EX_MD_Start,
    input  logic        MD_Done,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        ID_IRQ,
    output logic        ID_EXP,
    output logic [15:0] Stall_Cnt
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    localparam int SYNC_STAGES = 2;

    state_t                 state_reg;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   irq_s;
    logic                   irq_s_prev_reg;
    logic                   irq_rise;
    logic                   irq_pend_reg;
    logic                   irq_pend_next;
    logic [15:0]            stall_cnt_reg;
    logic [15:0]            stall_cnt_next;
    logic                   lu;

    // RUN-rule results, shared by RUN and by the MD_BUSY release cycle
    logic run_pc_write;
    logic run_ifid_write;
    logic run_ifid_flush;
    logic run_idex_flush;
    logic run_id_irq;
    logic run_id_exp;

    // -----------------------------------------------------------------------
    // Interrupt synchronizer and rising-edge detect
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg       <= '0;
            irq_s_prev_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], IRQ_in};
            irq_s_prev_reg <= irq_s;
        end
    end

    assign irq_s    = sync_reg[SYNC_STAGES-1];
    assign irq_rise = irq_s & ~irq_s_prev_reg;

    // A rise seen in kernel mode is dropped, not remembered. Taking the
    // interrupt wins over a new rise in the same cycle.
    always_comb begin
        irq_pend_next = irq_pend_reg;
        if (irq_rise && !Kernel) begin
            irq_pend_next = 1'b1;
        end
        if (ID_IRQ) begin
            irq_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend_reg <= 1'b0;
        end else begin
            irq_pend_reg <= irq_pend_next;
        end
    end

    // -----------------------------------------------------------------------
    // Load-use detect; $zero never carries a dependency
    // -----------------------------------------------------------------------
    assign lu = EX_MemRead && (EX_Rt != 5'd0) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    // -----------------------------------------------------------------------
    // RUN rules, highest priority first
    // -----------------------------------------------------------------------
    always_comb begin
        run_pc_write   = 1'b1;
        run_ifid_write = 1'b1;
        run_ifid_flush = 1'b0;
        run_idex_flush = 1'b0;
        run_id_irq     = 1'b0;
        run_id_exp     = 1'b0;
        if (EX_Branch_EN) begin
            // Everything younger than the branch is on the wrong path
            run_ifid_flush = 1'b1;
            run_idex_flush = 1'b1;
        end else if (ID_EXP_Req) begin
            run_id_exp     = 1'b1;
            run_ifid_flush = 1'b1;
            run_idex_flush = 1'b1;
        end else if (irq_pend_reg && !Kernel && !ID_Jump && !lu) begin
            // Interrupt is held off across a jump so the jump target is
            // not lost as the return point
            run_id_irq     = 1'b1;
            run_ifid_flush = 1'b1;
            run_idex_flush = 1'b1;
        end else if (ID_Jump && !lu) begin
            run_ifid_flush = 1'b1;
        end else if (lu) begin
            run_pc_write   = 1'b0;
            run_ifid_write = 1'b0;
            run_idex_flush = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                // A squashed mul/div must not freeze the pipe
                if (EX_MD_Start && !EX_Branch_EN) begin
                    state_next = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                if (MD_Done) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IDEX_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        ID_IRQ     = 1'b0;
        ID_EXP     = 1'b0;
        if (reset) begin
            if (state_reg == ST_RUN || MD_Done) begin
                PC_Write   = run_pc_write;
                IFID_Write = run_ifid_write;
                IFID_Flush = run_ifid_flush;
                IDEX_Flush = run_idex_flush;
                ID_IRQ     = run_id_irq;
                ID_EXP     = run_id_exp;
            end else begin
                // Waiting on mul/div: freeze the front end; pending
                // interrupts and exceptions stay queued
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Write = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter, saturating
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!PC_Write && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 16'd0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign Stall_Cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Inputs change 2 time units after a
// rising edge and outputs are sampled 1 unit later, well away from the edge.
// Expected values are hand-computed for each step.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        EX_Branch_EN;
    logic        ID_Jump;
    logic        ID_EXP_Req;
    logic        IRQ_in;
    logic        Kernel;
    logic        EX_MD_Start;
    logic        MD_Done;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IDEX_Write;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        ID_IRQ;
    logic        ID_EXP;
    logic [15:0] Stall_Cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .EX_MemRead   (EX_MemRead),
        .EX_Rt        (EX_Rt),
        .EX_Branch_EN (EX_Branch_EN),
        .ID_Jump      (ID_Jump),
        .ID_EXP_Req   (ID_EXP_Req),
        .IRQ_in       (IRQ_in),
        .Kernel       (Kernel),
        .EX_MD_Start  (EX_MD_Start),
        .MD_Done      (MD_Done),
        .PC_Write     (PC_Write),
        .IFID_Write   (IFID_Write),
        .IDEX_Write   (IDEX_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Flush   (IDEX_Flush),
        .ID_IRQ       (ID_IRQ),
        .ID_EXP       (ID_EXP),
        .Stall_Cnt    (Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bundle of the seven control outputs, bit order
    // {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, ID_IRQ, ID_EXP}
    function automatic logic [15:0] ctl();
        return {9'd0, PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, ID_IRQ, ID_EXP};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        ID_Rs        = 5'd0;
        ID_Rt        = 5'd0;
        ID_UsesRt    = 1'b0;
        EX_MemRead   = 1'b0;
        EX_Rt        = 5'd0;
        EX_Branch_EN = 1'b0;
        ID_Jump      = 1'b0;
        ID_EXP_Req   = 1'b0;
        Kernel       = 1'b0;
        EX_MD_Start  = 1'b0;
        MD_Done      = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        IRQ_in = 1'b0;
        clear_inputs();

        // ---- reset: defaults forced even with hazards present ----
        EX_Branch_EN = 1'b1;
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        $display("txn reset_hold      ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("reset_ctl", ctl(), 16'b111_0000);
        check("reset_cnt", Stall_Cnt, 16'd0);
        step();
        step();
        clear_inputs();
        reset = 1'b1;
        #1;
        check("post_reset_ctl", ctl(), 16'b111_0000);

        // ---- load-use on Rs ----
        step();
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        $display("txn load_use_rs     ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("lu_rs_ctl", ctl(), 16'b001_0100);
        step();
        clear_inputs();
        #1;
        check("lu_rs_release", ctl(), 16'b111_0000);
        check("lu_rs_cnt", Stall_Cnt, 16'd1);

        // ---- load to $zero: no stall ----
        EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
        #1;
        $display("txn load_zero       ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("lu_zero_ctl", ctl(), 16'b111_0000);
        step();
        clear_inputs();
        #1;
        check("lu_zero_cnt", Stall_Cnt, 16'd1);

        // ---- Rt match only counts when the ID instruction reads Rt ----
        EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
        #1;
        $display("txn rt_unused       ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("lu_rt_unused", ctl(), 16'b111_0000);
        ID_UsesRt = 1'b1;
        #1;
        $display("txn rt_used         ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("lu_rt_used", ctl(), 16'b001_0100);
        step();
        clear_inputs();
        #1;
        check("lu_rt_cnt", Stall_Cnt, 16'd2);

        // ---- branch beats exception, load-use and mul/div start ----
        EX_Branch_EN = 1'b1; ID_EXP_Req = 1'b1; EX_MD_Start = 1'b1;
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        $display("txn branch_prio     ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("branch_prio", ctl(), 16'b111_1100);
        step();
        clear_inputs();
        #1;
        check("branch_no_md", ctl(), 16'b111_0000);

        // ---- exception beats load-use ----
        ID_EXP_Req = 1'b1; EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        $display("txn exception       ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("exp_ctl", ctl(), 16'b111_1101);
        step();
        clear_inputs();

        // ---- jump alone, then jump with load-use ----
        ID_Jump = 1'b1;
        #1;
        $display("txn jump            ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("jump_ctl", ctl(), 16'b111_1000);
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        #1;
        $display("txn jump_lu         ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("jump_lu_ctl", ctl(), 16'b001_0100);
        step();
        clear_inputs();
        #1;
        check("jump_lu_cnt", Stall_Cnt, 16'd3);

        // ---- IRQ: taken exactly once, three edges after IRQ_in rises ----
        IRQ_in = 1'b1;
        step();
        #1;
        check("irq_e1", {15'd0, ID_IRQ}, 16'd0);
        step();
        #1;
        check("irq_e2", {15'd0, ID_IRQ}, 16'd0);
        step();
        #1;
        $display("txn irq_take        ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("irq_e3", ctl(), 16'b111_1110);
        step();
        #1;
        check("irq_once_a", {15'd0, ID_IRQ}, 16'd0);
        step();
        #1;
        check("irq_once_b", {15'd0, ID_IRQ}, 16'd0);
        IRQ_in = 1'b0;
        step(); step(); step();

        // ---- IRQ held off by a jump in ID ----
        IRQ_in = 1'b1;
        step();
        step();
        ID_Jump = 1'b1;
        step();
        #1;
        $display("txn irq_vs_jump     ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("irq_jump_e3", ctl(), 16'b111_1000);
        step();
        #1;
        check("irq_jump_e4", {15'd0, ID_IRQ}, 16'd0);
        ID_Jump = 1'b0;
        #1;
        $display("txn irq_after_jump  ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("irq_after_jump", ctl(), 16'b111_1110);
        step();
        #1;
        check("irq_after_once", {15'd0, ID_IRQ}, 16'd0);
        IRQ_in = 1'b0;
        step(); step(); step();

        // ---- IRQ rising in kernel mode is dropped ----
        Kernel = 1'b1;
        IRQ_in = 1'b1;
        step(); step(); step(); step();
        #1;
        check("irq_kernel_masked", {15'd0, ID_IRQ}, 16'd0);
        Kernel = 1'b0;
        #1;
        $display("txn irq_kernel      ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("irq_kernel_dropped", {15'd0, ID_IRQ}, 16'd0);
        IRQ_in = 1'b0;
        step(); step(); step();

        // ---- mul/div: five frozen cycles, then release ----
        EX_MD_Start = 1'b1;
        #1;
        check("md_start_ctl", ctl(), 16'b111_0000);
        step();
        EX_MD_Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // exception request must stay queued while busy
            ID_EXP_Req = (i == 2);
            #1;
            $display("txn md_busy[%0d]     ctl=%b cnt=%0d", i, ctl(), Stall_Cnt);
            check("md_busy_ctl", ctl(), 16'b000_0000);
            step();
        end
        ID_EXP_Req = 1'b0;
        MD_Done = 1'b1;
        #1;
        $display("txn md_done         ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("md_done_ctl", ctl(), 16'b111_0000);
        check("md_cnt", Stall_Cnt, 16'd8);
        step();
        MD_Done = 1'b0;
        #1;
        check("md_back_run", ctl(), 16'b111_0000);
        check("md_cnt_hold", Stall_Cnt, 16'd8);

        // ---- reset asserted mid mul/div ----
        EX_MD_Start = 1'b1;
        step();
        EX_MD_Start = 1'b0;
        #1;
        check("md2_busy", ctl(), 16'b000_0000);
        reset = 1'b0;
        #1;
        $display("txn reset_in_md     ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("md2_reset_ctl", ctl(), 16'b111_0000);
        check("md2_reset_cnt", Stall_Cnt, 16'd0);
        step();
        reset = 1'b1;
        #1;
        check("md2_release_ctl", ctl(), 16'b111_0000);
        step();
        #1;
        $display("txn after_reset     ctl=%b cnt=%0d", ctl(), Stall_Cnt);
        check("md2_run_ctl", ctl(), 16'b111_0000);
        check("md2_run_cnt", Stall_Cnt, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
